div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 113 +++++++++++
 1 files changed

// File: rtl/div.sv
// rtl/div.sv - sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
// Optional early termination for zero divisor / small dividend: define DIV_EARLY_EXIT_EN.
module div #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [2*WIDTH-1:0] out_q,
    output logic [WIDTH-1:0]   out_r,
    output logic               div_zero,
    output logic               busy,
    output logic               finish
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   qd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  rem_sh;
    logic [WIDTH-1:0] rem_nxt;
    logic            q_bit;
    logic            last_iter;
`ifdef DIV_EARLY_EXIT_EN
    logic            early;
`endif

    // qd holds the unconsumed dividend bits on the left and the quotient bits
    // shifted in on the right; a zero divisor naturally yields all-ones / in1 low bits.
    always_comb begin
        rem_sh    = {rem, qd[DW-1]};
        q_bit     = (rem_sh >= {1'b0, dvsr});
        rem_nxt   = q_bit ? (rem_sh[WIDTH-1:0] - dvsr) : rem_sh[WIDTH-1:0];
        last_iter = (cnt == CW'(DW - 1));
`ifdef DIV_EARLY_EXIT_EN
        early     = (in2 == '0) || (in1 < {{WIDTH{1'b0}}, in2});
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_EARLY_EXIT_EN
                    state_nxt = early ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qd       <= '0;
            rem      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            out_q    <= '0;
            out_r    <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        qd   <= in1;
                        dvsr <= in2;
                        rem  <= '0;
                        cnt  <= '0;
`ifdef DIV_EARLY_EXIT_EN
                        if (early) begin
                            out_q    <= (in2 == '0) ? {DW{1'b1}} : '0;
                            out_r    <= in1[WIDTH-1:0];
                            div_zero <= (in2 == '0);
                        end
`endif
                    end
                end
                RUN: begin
                    qd  <= {qd[DW-2:0], q_bit};
                    rem <= rem_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        out_q    <= {qd[DW-2:0], q_bit};
                        out_r    <= rem_nxt;
                        div_zero <= (dvsr == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign finish = (state == DONE);
endmodule
